// File: rtl/riscv_lsu_if.sv
// -----------------------------------------------------------------------------
// riscv_lsu_if
// Request/response handshake between the CPU and the load/store unit.
//   req_valid  CPU -> LSU  load/store request (held until accepted)
//   req_ready  LSU -> CPU  LSU is idle and accepts a request this cycle
//   req_store  CPU -> LSU  1 = store, 0 = load
//   req_func3  CPU -> LSU  RV32I func3 of the memory instruction
//   req_addr   CPU -> LSU  effective byte address
//   req_wdata  CPU -> LSU  store data (rs2)
//   rsp_valid  LSU -> CPU  one-cycle completion pulse
//   rsp_rdata  LSU -> CPU  load result, held until the next completion
//   rsp_err    LSU -> CPU  error flag, qualified by rsp_valid
// Modports: master = CPU side, slave = LSU side.
// -----------------------------------------------------------------------------
interface riscv_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_store, req_func3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_store, req_func3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu
// Load/store unit that owns the single RAM port. Instruction fetch uses the
// port whenever the unit is idle; RV32I loads/stores run as a multi-cycle
// transaction (sub-word stores as read-modify-write).
//
// Ports:
//   clk         clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   fetch_addr  CPU program counter (byte address)
//   fetch_data  RAM read data returned to the fetch stage
//   lsu         riscv_lsu_if.slave request/response handshake
//   ram_addr    word address to the RAM
//   ram_data    write data to the RAM
//   ram_wren    write enable to the RAM (one cycle, WRITE state only)
//   ram_q       RAM read data, one cycle after ram_addr
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into an error response with no RAM access. Without it the
// offending low address bits are simply ignored.
// -----------------------------------------------------------------------------
module riscv_lsu #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       fetch_data,
    riscv_lsu_if.slave        lsu,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q
);

    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              store_q;
    logic [2:0]        func3_q;
    logic [RAM_AW+1:0] addr_q;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              func3_ok;
    logic              misalign;
    logic [31:0]       byte_shift;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_fmt;
    logic [3:0]        byte_en;
    logic [31:0]       merged;
    logic              unused_bits;

    assign accept = (state_q == IDLE) && lsu.req_valid;

    // Legal encodings: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW.
    always_comb begin
        func3_ok = 1'b0;
        if (lsu.req_store) begin
            func3_ok = (lsu.req_func3 == 3'b000) || (lsu.req_func3 == 3'b001) ||
                       (lsu.req_func3 == 3'b010);
        end else begin
            func3_ok = (lsu.req_func3 == 3'b000) || (lsu.req_func3 == 3'b001) ||
                       (lsu.req_func3 == 3'b010) || (lsu.req_func3 == 3'b100) ||
                       (lsu.req_func3 == 3'b101);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // func3[1:0] encodes the size for every legal op: 01 = half, 10 = word.
    assign misalign = func3_ok &&
        (((lsu.req_func3[1:0] == 2'b01) && lsu.req_addr[0]) ||
         ((lsu.req_func3[1:0] == 2'b10) && (lsu.req_addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Load formatting from the word captured in CAPT.
    assign byte_shift = ram_q >> {addr_q[1:0], 3'b000};
    assign byte_sel   = byte_shift[7:0];
    assign half_sel   = addr_q[1] ? ram_q[31:16] : ram_q[15:0];

    always_comb begin
        load_fmt = ram_q;
        case (func3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'h0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'h0, half_sel};
            default: load_fmt = ram_q;
        endcase
    end

    // Lanes replaced by a store; SW replaces all four.
    always_comb begin
        byte_en = 4'b1111;
        case (func3_q[1:0])
            2'b00:   byte_en = 4'b0001 << addr_q[1:0];
            2'b01:   byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // data_q still holds rs2 here; SB feeds its low byte to every lane,
    // SH feeds its low half to both half positions.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_src;
            assign lane_src = (func3_q[1:0] == 2'b00) ? data_q[7:0]
                                                      : data_q[8*(gi%2) +: 8];
            assign merged[8*gi +: 8] = byte_en[gi] ? lane_src : ram_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (lsu.req_valid) begin
                    if (!func3_ok || misalign) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                        if (misalign) begin
                            rdata_d = 32'h0;
                        end
                    end else begin
                        err_d   = 1'b0;
                        data_d  = lsu.req_wdata;
                        state_d = (lsu.req_store && (lsu.req_func3 == 3'b010)) ? WRITE : READ;
                    end
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                if (store_q) begin
                    data_d  = merged;
                    state_d = WRITE;
                end else begin
                    rdata_d = load_fmt;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= '0;
            data_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                store_q <= lsu.req_store;
                func3_q <= lsu.req_func3;
                addr_q  <= lsu.req_addr[RAM_AW+1:0];
            end
        end
    end

    // Fetch owns the RAM port only while idle.
    assign ram_addr      = (state_q == IDLE) ? fetch_addr[RAM_AW+1:2] : addr_q[RAM_AW+1:2];
    assign ram_data      = data_q;
    assign ram_wren      = (state_q == WRITE);
    assign fetch_data    = ram_q;

    assign lsu.req_ready = (state_q == IDLE);
    assign lsu.rsp_valid = (state_q == RESP);
    assign lsu.rsp_rdata = rdata_q;
    assign lsu.rsp_err   = err_q;

    // Address bits above the RAM and the byte offset of the PC are dropped.
    assign unused_bits = ^{fetch_addr[31:RAM_AW+2], fetch_addr[1:0], lsu.req_addr[31:RAM_AW+2]};

endmodule
